dma_task_ctrl: RTL and testbench

Descriptor-level task controller that sits directly downstream of the AXI-Lite CSR block. It consumes the CSR start pulse, base address, length and hardware-init pulse, and splits each task into read-burst commands for the DMA read engine. It tracks outstanding bursts and completions, and returns the `done` and `error` status that the CSR block reports in its STATUS register.

---
 rtl/dma_task_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_dma_task_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_task_ctrl.sv
// Descriptor-level DMA task controller: splits a CSR-programmed task into
// window-aligned read bursts, tracks outstanding bursts and reports done/error.
module dma_task_ctrl #(
    parameter int ADDR_WIDTH      = 32,
    parameter int MAX_BURST_BYTES = 256,
    parameter int MAX_OUTSTANDING = 4,
    parameter int TIMEOUT_CYCLES  = 65535
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               i_start,
    input  logic                               i_hw_init,
    input  logic [ADDR_WIDTH-1:0]              i_base_addr,
    input  logic [31:0]                        i_len,
    output logic                               o_cmd_valid,
    input  logic                               i_cmd_ready,
    output logic [ADDR_WIDTH-1:0]              o_cmd_addr,
    output logic [$clog2(MAX_BURST_BYTES):0]   o_cmd_len,
    input  logic                               i_cpl_valid,
    input  logic                               i_cpl_err,
    output logic                               o_busy,
    output logic                               o_done,
    output logic                               o_error
);

    localparam int OFF_W = $clog2(MAX_BURST_BYTES);
    localparam int LEN_W = OFF_W + 1;
    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        ISSUE,
        DRAIN,
        DONE,
        ERR
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           remaining_q, remaining_d;
    logic [OUT_W-1:0]      outstanding_q, outstanding_d;
    logic [TO_W-1:0]       timeout_q, timeout_d;
    logic                  errFlag_q, errFlag_d;
    logic                  cmdValid_q, cmdValid_d;
    logic [ADDR_WIDTH-1:0] cmdAddr_q, cmdAddr_d;
    logic [LEN_W-1:0]      cmdLen_q, cmdLen_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic                  busy_q, busy_d;

    logic                  cmdFire;
    logic                  cplFire;
    logic                  holdCmd;
    logic                  errNext;
    logic                  timeoutHit;
    logic [OUT_W-1:0]      outNext;
    logic [ADDR_WIDTH-1:0] addrAfter;
    logic [31:0]           remAfter;

    // Largest burst from addr that neither overruns the task nor crosses a window.
    function automatic logic [LEN_W-1:0] burstLen(input logic [ADDR_WIDTH-1:0] a,
                                                  input logic [31:0]           r);
        logic [LEN_W-1:0] room;
        room = LEN_W'(MAX_BURST_BYTES) - LEN_W'(a[OFF_W-1:0]);
        if (r < 32'(room)) begin
            return LEN_W'(r);
        end
        return room;
    endfunction

    assign cmdFire    = cmdValid_q & i_cmd_ready;
    assign cplFire    = i_cpl_valid & (outstanding_q != '0);
    assign holdCmd    = cmdValid_q & ~i_cmd_ready;
    assign errNext    = errFlag_q | (cplFire & i_cpl_err);
    assign timeoutHit = (timeout_q == TO_W'(TIMEOUT_CYCLES - 1));
    assign outNext    = outstanding_q + OUT_W'(cmdFire) - OUT_W'(cplFire);
    assign addrAfter  = cmdFire ? addr_q + ADDR_WIDTH'(cmdLen_q) : addr_q;
    assign remAfter   = cmdFire ? remaining_q - 32'(cmdLen_q) : remaining_q;

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        remaining_d   = remaining_q;
        outstanding_d = outstanding_q;
        timeout_d     = timeout_q;
        errFlag_d     = errFlag_q;
        cmdValid_d    = cmdValid_q;
        cmdAddr_d     = cmdAddr_q;
        cmdLen_d      = cmdLen_q;
        done_d        = done_q;
        error_d       = error_q;

        if (i_hw_init) begin
            state_d       = IDLE;
            outstanding_d = '0;
            timeout_d     = '0;
            errFlag_d     = 1'b0;
            cmdValid_d    = 1'b0;
            done_d        = 1'b0;
            error_d       = 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE, ERR: begin
                    if (i_start) begin
                        state_d     = CHECK;
                        addr_d      = i_base_addr;
                        remaining_d = i_len;
                        timeout_d   = '0;
                        errFlag_d   = 1'b0;
                        done_d      = 1'b0;
                        error_d     = 1'b0;
                    end
                end
                CHECK: begin
                    // Tasks must be whole 16-byte AES blocks on a block boundary.
                    if (remaining_q == '0 || remaining_q[3:0] != '0 || addr_q[3:0] != '0) begin
                        state_d = ERR;
                        error_d = 1'b1;
                    end else begin
                        state_d    = ISSUE;
                        cmdValid_d = 1'b1;
                        cmdAddr_d  = addr_q;
                        cmdLen_d   = burstLen(addr_q, remaining_q);
                    end
                end
                ISSUE, DRAIN: begin
                    outstanding_d = outNext;
                    addr_d        = addrAfter;
                    remaining_d   = remAfter;
                    errFlag_d     = errNext;
                    timeout_d     = (cmdFire || cplFire) ? '0 : timeout_q + 1'b1;
                    if (!cmdFire && !cplFire && timeoutHit) begin
                        state_d       = ERR;
                        error_d       = 1'b1;
                        outstanding_d = '0;
                        timeout_d     = '0;
                        cmdValid_d    = 1'b0;
                    end else if (state_q == DRAIN) begin
                        if (outNext == '0) begin
                            state_d = errNext ? ERR : DONE;
                            error_d = errNext;
                            done_d  = ~errNext;
                        end
                    end else if (!holdCmd) begin
                        // A presented command is never withdrawn, so decisions wait for its handshake.
                        if (remAfter == '0 || errNext) begin
                            state_d    = DRAIN;
                            cmdValid_d = 1'b0;
                        end else if (outNext < OUT_W'(MAX_OUTSTANDING)) begin
                            cmdValid_d = 1'b1;
                            cmdAddr_d  = addrAfter;
                            cmdLen_d   = burstLen(addrAfter, remAfter);
                        end else begin
                            cmdValid_d = 1'b0;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        busy_d = (state_d == CHECK) || (state_d == ISSUE) || (state_d == DRAIN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            remaining_q   <= '0;
            outstanding_q <= '0;
            timeout_q     <= '0;
            errFlag_q     <= 1'b0;
            cmdValid_q    <= 1'b0;
            cmdAddr_q     <= '0;
            cmdLen_q      <= '0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            remaining_q   <= remaining_d;
            outstanding_q <= outstanding_d;
            timeout_q     <= timeout_d;
            errFlag_q     <= errFlag_d;
            cmdValid_q    <= cmdValid_d;
            cmdAddr_q     <= cmdAddr_d;
            cmdLen_q      <= cmdLen_d;
            done_q        <= done_d;
            error_q       <= error_d;
            busy_q        <= busy_d;
        end
    end

    assign o_cmd_valid = cmdValid_q;
    assign o_cmd_addr  = cmdAddr_q;
    assign o_cmd_len   = cmdLen_q;
    assign o_busy      = busy_q;
    assign o_done      = done_q;
    assign o_error     = error_q;

endmodule

// File: tb/tb_dma_task_ctrl.sv
// Self-checking bench for dma_task_ctrl: table-driven tasks with a command
// scoreboard, plus hand-written limit, error, abort and timeout sequences.
module tb_dma_task_ctrl;

    logic        clk;
    logic        rst_n;
    logic        i_start;
    logic        i_hw_init;
    logic [31:0] i_base_addr;
    logic [31:0] i_len;
    logic        o_cmd_valid;
    logic        i_cmd_ready;
    logic [31:0] o_cmd_addr;
    logic [8:0]  o_cmd_len;
    logic        i_cpl_valid;
    logic        i_cpl_err;
    logic        o_busy;
    logic        o_done;
    logic        o_error;

    typedef struct {
        logic [31:0] addr;
        logic [8:0]  len;
    } cmd_t;

    typedef struct {
        logic [31:0] base;
        logic [31:0] len;
        int          nCmd;
        bit          expErr;
    } vec_t;

    cmd_t expQ[$];
    vec_t vecs[7];
    int   total;
    int   bad;
    int   issuedCnt;
    int   startIss;
    int   errAt;

    dma_task_ctrl #(
        .ADDR_WIDTH     (32),
        .MAX_BURST_BYTES(256),
        .MAX_OUTSTANDING(4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_start    (i_start),
        .i_hw_init  (i_hw_init),
        .i_base_addr(i_base_addr),
        .i_len      (i_len),
        .o_cmd_valid(o_cmd_valid),
        .i_cmd_ready(i_cmd_ready),
        .o_cmd_addr (o_cmd_addr),
        .o_cmd_len  (o_cmd_len),
        .i_cpl_valid(i_cpl_valid),
        .i_cpl_err  (i_cpl_err),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_error    (o_error)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the run stalls somewhere unbounded.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference split of a task into window-aligned bursts, queued as expected commands.
    task automatic pushModel(input logic [31:0] base, input logic [31:0] len, input int maxCmds);
        logic [31:0] a;
        logic [31:0] r;
        logic [31:0] room;
        logic [31:0] b;
        int          n;
        cmd_t        c;
        a = base;
        r = len;
        n = 0;
        while (r != 32'd0 && n < maxCmds) begin
            room = 32'd256 - {24'd0, a[7:0]};
            b    = (r < room) ? r : room;
            c.addr = a;
            c.len  = b[8:0];
            expQ.push_back(c);
            a = a + b;
            r = r - b;
            n++;
        end
    endtask

    // One clock: scoreboard any handshake at the coming edge, then return just after it.
    task automatic step();
        cmd_t e;
        @(negedge clk);
        if (o_cmd_valid && i_cmd_ready) begin
            issuedCnt++;
            checkOutput("cmdExpected", 64'(expQ.size() != 0), 64'd1);
            if (expQ.size() != 0) begin
                e = expQ.pop_front();
                checkOutput("cmdAddr", 64'(o_cmd_addr), 64'(e.addr));
                checkOutput("cmdLen", 64'(o_cmd_len), 64'(e.len));
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Pulse start and return at T+2, checking the CHECK cycle on the way.
    task automatic applyStimulus(input logic [31:0] base, input logic [31:0] len);
        i_base_addr = base;
        i_len       = len;
        i_start     = 1'b1;
        step();
        i_start = 1'b0;
        checkOutput("checkBusy", 64'(o_busy), 64'd1);
        checkOutput("startClears", 64'({o_done, o_error}), 64'd0);
        step();
    endtask

    // Return one completion per issued burst until nCmd completions are delivered.
    task automatic runTask(input int nCmd, input int iss0, input int cplAlready);
        int given;
        bit fin;
        given = cplAlready;
        fin   = 1'b0;
        for (int c = 0; c < 200 && !fin; c++) begin
            i_cpl_valid = ((issuedCnt - iss0) > given);
            if (i_cpl_valid) given++;
            step();
            if (i_cpl_valid && given == nCmd) fin = 1'b1;
        end
        i_cpl_valid = 1'b0;
        checkOutput("allCompleted", 64'(fin), 64'd1);
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        issuedCnt   = 0;
        rst_n       = 1'b0;
        i_start     = 1'b0;
        i_hw_init   = 1'b0;
        i_base_addr = '0;
        i_len       = '0;
        i_cmd_ready = 1'b0;
        i_cpl_valid = 1'b0;
        i_cpl_err   = 1'b0;

        vecs[0] = '{32'h0000_1000, 32'h40,  1, 1'b0};
        vecs[1] = '{32'h0000_10C0, 32'h200, 3, 1'b0};
        vecs[2] = '{32'h0000_2000, 32'h18,  0, 1'b1};
        vecs[3] = '{32'h0000_2000, 32'h100, 1, 1'b0};
        vecs[4] = '{32'h0000_2000, 32'h0,   0, 1'b1};
        vecs[5] = '{32'h0000_3008, 32'h40,  0, 1'b1};
        vecs[6] = '{32'hFFFF_FFC0, 32'h80,  2, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rstFlags", 64'({o_cmd_valid, o_busy, o_done, o_error}), 64'd0);
        checkOutput("rstAddr", 64'(o_cmd_addr), 64'd0);
        checkOutput("rstLen", 64'(o_cmd_len), 64'd0);
        rst_n = 1'b1;
        step();
        checkOutput("idleFlags", 64'({o_cmd_valid, o_busy, o_done, o_error}), 64'd0);

        // Table-driven tasks: clean ones run to done, bad ones must fail at T+2.
        i_cmd_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            startIss = issuedCnt;
            if (!vecs[i].expErr) pushModel(vecs[i].base, vecs[i].len, 1000);
            applyStimulus(vecs[i].base, vecs[i].len);
            if (vecs[i].expErr) begin
                checkOutput("chkError", 64'(o_error), 64'd1);
                checkOutput("chkNoValid", 64'(o_cmd_valid), 64'd0);
                checkOutput("chkNotBusy", 64'(o_busy), 64'd0);
                step();
                step();
                checkOutput("chkNoCmds", 64'(issuedCnt - startIss), 64'd0);
                checkOutput("chkErrHeld", 64'(o_error), 64'd1);
            end else begin
                checkOutput("firstValid", 64'(o_cmd_valid), 64'd1);
                checkOutput("firstBusy", 64'(o_busy), 64'd1);
                runTask(vecs[i].nCmd, startIss, 0);
                checkOutput("taskDone", 64'(o_done), 64'd1);
                checkOutput("taskNoErr", 64'(o_error), 64'd0);
                checkOutput("taskIdle", 64'(o_busy), 64'd0);
                checkOutput("taskCmds", 64'(issuedCnt - startIss), 64'(vecs[i].nCmd));
                checkOutput("queueEmpty", 64'(expQ.size()), 64'd0);
            end
        end

        // Outstanding limit: saturate at four, release one per completion.
        startIss = issuedCnt;
        pushModel(32'h0, 32'h800, 8);
        applyStimulus(32'h0, 32'h800);
        repeat (6) step();
        checkOutput("limitCmds", 64'(issuedCnt - startIss), 64'd4);
        checkOutput("limitValid", 64'(o_cmd_valid), 64'd0);
        i_cpl_valid = 1'b1;
        step();
        i_cpl_valid = 1'b0;
        checkOutput("releaseValid", 64'(o_cmd_valid), 64'd1);
        repeat (3) step();
        checkOutput("releaseCmds", 64'(issuedCnt - startIss), 64'd5);
        checkOutput("releaseLimit", 64'(o_cmd_valid), 64'd0);
        i_cpl_valid = 1'b1;
        step();
        step();
        i_cpl_valid = 1'b0;
        step();
        step();
        checkOutput("coincCmds", 64'(issuedCnt - startIss), 64'd7);
        checkOutput("coincLimit", 64'(o_cmd_valid), 64'd0);
        runTask(8, startIss, 3);
        checkOutput("limitDone", 64'(o_done), 64'd1);
        checkOutput("limitQueue", 64'(expQ.size()), 64'd0);

        // Completion error: second completion errors, issuing stops, error after drain.
        startIss = issuedCnt;
        pushModel(32'h8000, 32'h800, 5);
        applyStimulus(32'h8000, 32'h800);
        repeat (6) step();
        i_cpl_valid = 1'b1;
        step();
        i_cpl_valid = 1'b0;
        step();
        i_cpl_valid = 1'b1;
        i_cpl_err   = 1'b1;
        step();
        i_cpl_valid = 1'b0;
        i_cpl_err   = 1'b0;
        step();
        step();
        checkOutput("errNoValid", 64'(o_cmd_valid), 64'd0);
        checkOutput("errDraining", 64'({o_busy, o_error}), 64'b10);
        i_cpl_valid = 1'b1;
        step();
        step();
        i_cpl_valid = 1'b0;
        checkOutput("errStillBusy", 64'({o_busy, o_error}), 64'b10);
        i_cpl_valid = 1'b1;
        step();
        i_cpl_valid = 1'b0;
        checkOutput("errFlags", 64'({o_busy, o_done, o_error}), 64'b001);
        step();
        step();
        checkOutput("errCmds", 64'(issuedCnt - startIss), 64'd5);
        checkOutput("errQueue", 64'(expQ.size()), 64'd0);

        // Abort mid-ISSUE, then a stray completion must not disturb the next task.
        startIss = issuedCnt;
        pushModel(32'h5000, 32'h800, 2);
        applyStimulus(32'h5000, 32'h800);
        step();
        step();
        i_cmd_ready = 1'b0;
        i_hw_init   = 1'b1;
        step();
        i_hw_init = 1'b0;
        checkOutput("abortFlags", 64'({o_cmd_valid, o_busy, o_done, o_error}), 64'd0);
        checkOutput("abortCmds", 64'(issuedCnt - startIss), 64'd2);
        i_cpl_valid = 1'b1;
        step();
        i_cpl_valid = 1'b0;
        step();
        checkOutput("strayFlags", 64'({o_cmd_valid, o_busy, o_done, o_error}), 64'd0);
        i_cmd_ready = 1'b1;
        startIss    = issuedCnt;
        pushModel(32'h6000, 32'h40, 8);
        applyStimulus(32'h6000, 32'h40);
        checkOutput("postAbortValid", 64'(o_cmd_valid), 64'd1);
        runTask(1, startIss, 0);
        checkOutput("postAbortDone", 64'({o_done, o_error}), 64'b10);

        // Hardware init wins over a same-cycle start.
        i_base_addr = 32'h7000;
        i_len       = 32'h40;
        i_start     = 1'b1;
        i_hw_init   = 1'b1;
        step();
        i_start   = 1'b0;
        i_hw_init = 1'b0;
        checkOutput("initPrio", 64'({o_busy, o_done, o_error}), 64'd0);
        step();
        checkOutput("initPrioIdle", 64'({o_cmd_valid, o_busy}), 64'd0);

        // Timeout: command held without ready must abort after 16 idle cycles.
        i_cmd_ready = 1'b0;
        startIss    = issuedCnt;
        applyStimulus(32'h4000, 32'h40);
        checkOutput("toValid", 64'(o_cmd_valid), 64'd1);
        errAt = -1;
        for (int k = 1; k <= 30 && errAt < 0; k++) begin
            step();
            if (k == 8) begin
                checkOutput("toHoldValid", 64'(o_cmd_valid), 64'd1);
                checkOutput("toHoldAddr", 64'(o_cmd_addr), 64'h4000);
                checkOutput("toHoldLen", 64'(o_cmd_len), 64'd64);
            end
            if (o_error) errAt = k;
        end
        checkOutput("toCycles", 64'(errAt), 64'd16);
        checkOutput("toFlags", 64'({o_cmd_valid, o_busy, o_done}), 64'd0);
        checkOutput("toNoCmds", 64'(issuedCnt - startIss), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
